// File: rtl/m_definitions.sv
// Shared M-extension definitions.
// Holds the R-type opcode/funct7 constants for RV32M, instruction field
// getters, the M-instruction classifier and the PCPI arbiter state enum.
package m_definitions;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

    // Getters mask/shift the whole word before truncating.
    function automatic logic [6:0] insn_opcode(input logic [31:0] insn);
        return 7'(insn & 32'h0000_007F);
    endfunction

    function automatic logic [6:0] insn_funct7(input logic [31:0] insn);
        return 7'(insn >> 25);
    endfunction

    function automatic logic is_m_insn(input logic [31:0] insn);
        return (insn_opcode(insn) == OPCODE_OP) && (insn_funct7(insn) == FUNCT7_MULDIV);
    endfunction

endpackage

// File: rtl/m_pcpi_arbiter_if.sv
// Bus bundle for the PCPI arbiter.
// Carries two requester channels (req0_*, req1_*) and the PCPI channel to
// the shared M unit.
//   master : arbiter view (takes requests and unit replies, drives results
//            and the pcpi request)
//   slave  : environment view (requesters plus M unit)
interface m_pcpi_arbiter_if;

    logic        req0_valid, req0_ready, req0_wr, req0_busy;
    logic [31:0] req0_insn, req0_rs1, req0_rs2, req0_rd;
    logic        req1_valid, req1_ready, req1_wr, req1_busy;
    logic [31:0] req1_insn, req1_rs1, req1_rs2, req1_rd;

    logic        pcpi_valid;
    logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
    logic        pcpi_ready, pcpi_wr, pcpi_busy;
    logic [31:0] pcpi_rd;

    modport master (
        input  req0_valid, req0_insn, req0_rs1, req0_rs2,
        input  req1_valid, req1_insn, req1_rs1, req1_rs2,
        output req0_ready, req0_wr, req0_rd, req0_busy,
        output req1_ready, req1_wr, req1_rd, req1_busy,
        output pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        input  pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy
    );

    modport slave (
        output req0_valid, req0_insn, req0_rs1, req0_rs2,
        output req1_valid, req1_insn, req1_rs1, req1_rs2,
        input  req0_ready, req0_wr, req0_rd, req0_busy,
        input  req1_ready, req1_wr, req1_rd, req1_busy,
        input  pcpi_valid, pcpi_insn, pcpi_rs1, pcpi_rs2,
        output pcpi_ready, pcpi_wr, pcpi_rd, pcpi_busy
    );

endinterface

// File: rtl/m_rr_grant2.sv
// Two-way round-robin grant.
// Ports: req[1:0] requests, last = index granted last time,
//        grant[1:0] one-hot grant (zero when no request).
module m_rr_grant2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On a tie, the requester that was not served last wins.
        if (req == 2'b11)
            grant = last ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/m_pcpi_arbiter.sv
// PCPI arbiter: shares one M unit between two requesters.
// Ports: clk, resetn (synchronous, active-high),
//        bus (master modport: requester channels + PCPI channel),
//        err_timeout (one-cycle pulse when the unit fails to answer in time).
// Eligible M instructions go through BUSY to the unit. Any other valid
// request is answered directly with wr=0, rd=0. A requester that drops
// valid while its transaction is in BUSY gets no ready pulse.
module m_pcpi_arbiter
    import m_definitions::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              resetn,
    m_pcpi_arbiter_if.master  bus,
    output logic              err_timeout
);

    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    arb_state_e  state_q, state_d;
    logic        last_q, gnt_q, flush_q, wr_q, err_q;
    logic [TW-1:0] timer_q;
    logic [31:0] insn_q, rs1_q, rs2_q, rd_q;

    logic [1:0]  vld, elig, rr_req, rr_gnt;
    logic        gnt_idx, gnt_valid, timeout, resp_ok;

    assign vld  = {bus.req1_valid, bus.req0_valid};
    assign elig = {bus.req1_valid && is_m_insn(bus.req1_insn),
                   bus.req0_valid && is_m_insn(bus.req0_insn)};
    // M requests take priority; otherwise arbitrate among plain requests.
    assign rr_req = (|elig) ? elig : vld;

    m_rr_grant2 u_rr (
        .req   (rr_req),
        .last  (last_q),
        .grant (rr_gnt)
    );

    assign gnt_idx   = rr_gnt[1];
    assign gnt_valid = gnt_q ? bus.req1_valid : bus.req0_valid;
    assign timeout   = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB_IDLE: begin
                if (|elig)      state_d = ARB_BUSY;
                else if (|vld)  state_d = ARB_RESP;
            end
            ARB_BUSY: if (bus.pcpi_ready || timeout) state_d = ARB_RESP;
            ARB_RESP: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b1;
            gnt_q   <= 1'b0;
            flush_q <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            timer_q <= '0;
            insn_q  <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= 1'b0;
            case (state_q)
                ARB_IDLE: if (|vld) begin
                    gnt_q   <= gnt_idx;
                    last_q  <= gnt_idx;
                    flush_q <= 1'b0;
                    timer_q <= '0;
                    wr_q    <= 1'b0;
                    rd_q    <= '0;
                    if (|elig) begin
                        insn_q <= gnt_idx ? bus.req1_insn : bus.req0_insn;
                        rs1_q  <= gnt_idx ? bus.req1_rs1  : bus.req0_rs1;
                        rs2_q  <= gnt_idx ? bus.req1_rs2  : bus.req0_rs2;
                    end
                end
                ARB_BUSY: begin
                    timer_q <= timer_q + 1'b1;
                    // Requester withdrew: let the unit finish, drop the result.
                    if (!gnt_valid) flush_q <= 1'b1;
                    if (bus.pcpi_ready) begin
                        wr_q <= bus.pcpi_wr;
                        rd_q <= bus.pcpi_rd;
                    end else if (timeout) begin
                        wr_q  <= 1'b0;
                        rd_q  <= '0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_ok = (state_q == ARB_RESP) && !flush_q;

    assign bus.req0_ready = resp_ok && !gnt_q && bus.req0_valid;
    assign bus.req1_ready = resp_ok &&  gnt_q && bus.req1_valid;
    assign bus.req0_wr    = bus.req0_ready && wr_q;
    assign bus.req1_wr    = bus.req1_ready && wr_q;
    assign bus.req0_rd    = bus.req0_ready ? rd_q : 32'd0;
    assign bus.req1_rd    = bus.req1_ready ? rd_q : 32'd0;
    assign bus.req0_busy  = bus.req0_valid && !bus.req0_ready;
    assign bus.req1_busy  = bus.req1_valid && !bus.req1_ready;

    assign bus.pcpi_valid = (state_q == ARB_BUSY);
    assign bus.pcpi_insn  = insn_q;
    assign bus.pcpi_rs1   = rs1_q;
    assign bus.pcpi_rs2   = rs2_q;
    assign err_timeout    = err_q;

    // pcpi_busy is monitored only; grant bit 0 is implied by bit 1.
    logic unused_sig;
    assign unused_sig = ^{bus.pcpi_busy, rr_gnt[0]};

endmodule

// File: tb/tb_m_pcpi_arbiter.sv
// Self-checking bench for m_pcpi_arbiter. The reference model works at
// transaction level: which requester is served, how long pcpi_valid stays
// up, and what result (if any) the requester receives.
module tb_m_pcpi_arbiter;

    localparam int TO = 64;

    logic clk = 1'b0;
    logic resetn;
    logic err_timeout;
    int   nchk = 0;
    int   nerr = 0;

    m_pcpi_arbiter_if bus();

    m_pcpi_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .bus         (bus.master),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: an M instruction is opcode 0x33 with funct7 == 1.
    function automatic bit is_m(input logic [31:0] i);
        return ((i & 32'h7F) == 32'h33) && ((i >> 25) == 32'h1);
    endfunction

    function automatic logic [31:0] rand_insn(input int kind);
        logic [31:0] r;
        r = $urandom;
        case (kind)
            0:       return (r & 32'h01FF_FF80) | 32'h0200_0033; // M op
            1:       return (r & 32'h01FF_FF80) | 32'h0000_0033; // base ALU op
            default: return (r & 32'hFFFF_FF80) | 32'h0000_0013; // OP-IMM
        endcase
    endfunction

    task automatic set_req(input int who, input logic v, input logic [31:0] i, a, b);
        if (who == 0) begin
            bus.req0_valid = v; bus.req0_insn = i; bus.req0_rs1 = a; bus.req0_rs2 = b;
        end else begin
            bus.req1_valid = v; bus.req1_insn = i; bus.req1_rs1 = a; bus.req1_rs2 = b;
        end
    endtask

    function automatic logic rdy_of(input int who);
        return (who == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction
    function automatic logic wr_of(input int who);
        return (who == 0) ? bus.req0_wr : bus.req1_wr;
    endfunction
    function automatic logic [31:0] rd_of(input int who);
        return (who == 0) ? bus.req0_rd : bus.req1_rd;
    endfunction
    function automatic logic busy_of(input int who);
        return (who == 0) ? bus.req0_busy : bus.req1_busy;
    endfunction

    // One request from one requester, arbiter idle at entry (called on a
    // negedge). lat = BUSY cycle in which the unit answers (0 = never);
    // drop = BUSY cycle in which the requester withdraws (0 = never).
    // The unit answers rs1*rs2.
    task automatic run_txn(input int who, input logic [31:0] insn, rs1, rs2,
                           input int lat, input int drop);
        bit          m, keep, dropped;
        int          vcnt, exp_v;
        logic        exp_wr, exp_err;
        logic [31:0] exp_rd;
        m       = is_m(insn);
        exp_v   = !m ? 0 : ((lat == 0) ? TO : lat);
        exp_wr  = m && (lat != 0);
        exp_rd  = exp_wr ? rs1 * rs2 : 32'd0;
        exp_err = m && (lat == 0);
        keep    = !(drop > 0 && drop <= exp_v);
        dropped = 0;
        bus.pcpi_ready = 0; bus.pcpi_wr = 0; bus.pcpi_rd = 0;
        set_req(who, 1'b1, insn, rs1, rs2);
        @(negedge clk);
        vcnt = 0;
        for (int c = 1; c <= TO + 20 && bus.pcpi_valid; c++) begin
            vcnt++;
            if (c == 1) begin
                chk("pcpi_insn", bus.pcpi_insn, insn);
                chk("pcpi_rs1", bus.pcpi_rs1, rs1);
                chk("pcpi_rs2", bus.pcpi_rs2, rs2);
                chk("busy_rdy", rdy_of(who), 1'b0);
            end
            if (!dropped) chk("busy_stall", busy_of(who), 1'b1);
            if (c == drop) begin
                set_req(who, 1'b0, insn, rs1, rs2);
                dropped = 1;
            end
            if (c == lat) begin
                bus.pcpi_ready = 1; bus.pcpi_wr = 1; bus.pcpi_rd = rs1 * rs2;
            end
            @(negedge clk);
            bus.pcpi_ready = 0; bus.pcpi_wr = 0; bus.pcpi_rd = 0;
        end
        chk("pv_cycles", vcnt, exp_v);
        chk("resp_ready", rdy_of(who), keep);
        chk("resp_wr", wr_of(who), keep && exp_wr);
        chk("resp_rd", rd_of(who), keep ? exp_rd : 32'd0);
        chk("resp_err", err_timeout, exp_err);
        chk("other_ready", rdy_of(1 - who), 1'b0);
        set_req(who, 1'b0, insn, rs1, rs2);
        @(negedge clk);
        chk("idle_ready", rdy_of(who), 1'b0);
        chk("idle_rd", rd_of(who), 32'd0);
        chk("idle_err", err_timeout, 1'b0);
        chk("idle_pv", bus.pcpi_valid, 1'b0);
        // Stray unit reply while idle must be ignored.
        if ($urandom_range(0, 2) == 0) begin
            bus.pcpi_ready = 1; bus.pcpi_wr = 1; bus.pcpi_rd = $urandom;
        end
    endtask

    initial begin
        logic [31:0] ri[2], r1[2], r2[2];
        int last, exp_g, n, lat, who, kind, drop;

        resetn = 1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        bus.pcpi_ready = 0; bus.pcpi_wr = 0; bus.pcpi_rd = 0; bus.pcpi_busy = 0;
        repeat (2) @(negedge clk);
        chk("rst_pv", bus.pcpi_valid, 1'b0);
        chk("rst_insn", bus.pcpi_insn, 32'd0);
        chk("rst_rs1", bus.pcpi_rs1, 32'd0);
        chk("rst_r0", bus.req0_ready, 1'b0);
        chk("rst_r1", bus.req1_ready, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        resetn = 0;

        // Round robin with both requesters permanently eligible.
        last = 1;
        for (int k = 0; k < 2; k++) begin
            ri[k] = rand_insn(0); r1[k] = $urandom; r2[k] = $urandom;
            set_req(k, 1, ri[k], r1[k], r2[k]);
        end
        for (int t = 0; t < 4; t++) begin
            exp_g = 1 - last;
            n = 0;
            while (!bus.pcpi_valid && n < 6) begin @(negedge clk); n++; end
            chk("rr_latency", n, (t == 0) ? 1 : 2);
            chk("rr_insn", bus.pcpi_insn, ri[exp_g]);
            chk("rr_rs1", bus.pcpi_rs1, r1[exp_g]);
            lat = $urandom_range(1, 3);
            for (int c = 1; c < lat; c++) @(negedge clk);
            bus.pcpi_ready = 1; bus.pcpi_wr = 1; bus.pcpi_rd = r1[exp_g] * r2[exp_g];
            @(negedge clk);
            bus.pcpi_ready = 0; bus.pcpi_wr = 0; bus.pcpi_rd = 0;
            chk("rr_grant", rdy_of(exp_g), 1'b1);
            chk("rr_other", rdy_of(1 - exp_g), 1'b0);
            chk("rr_rd", rd_of(exp_g), r1[exp_g] * r2[exp_g]);
            last = exp_g;
            ri[exp_g] = rand_insn(0); r1[exp_g] = $urandom; r2[exp_g] = $urandom;
            set_req(exp_g, 1, ri[exp_g], r1[exp_g], r2[exp_g]);
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        @(negedge clk);

        // Worked example: 7*6 after 4 BUSY cycles.
        run_txn(0, 32'h02B5_0533, 32'd7, 32'd6, 4, 0);
        // Plain ADD from req1: answered directly.
        run_txn(1, 32'h00B5_0533, 32'd3, 32'd4, 0, 0);
        // Silent unit: timeout.
        run_txn(0, 32'h02B5_0533, 32'd9, 32'd9, 0, 0);
        // Flush: req0 withdraws in BUSY, unit later answers 5.
        run_txn(0, 32'h02B5_0533, 32'd5, 32'd1, 6, 2);
        run_txn(0, 32'h02B5_0533, 32'd11, 32'd3, 2, 0);

        // Randomized single transactions.
        for (int t = 0; t < 24; t++) begin
            who  = $urandom_range(0, 1);
            kind = $urandom_range(0, 2);
            lat  = $urandom_range(1, 6);
            drop = ($urandom_range(0, 4) == 0) ? $urandom_range(1, lat) : 0;
            run_txn(who, rand_insn(kind), $urandom, $urandom, lat, drop);
        end

        // Reset in BUSY cycle 3, then req0 wins the first tie.
        bus.pcpi_ready = 0; bus.pcpi_wr = 0; bus.pcpi_rd = 0;
        set_req(1, 1, 32'h02B5_0533, 32'd2, 32'd2);
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk("pre_rst_pv", bus.pcpi_valid, 1'b1);
        resetn = 1;
        set_req(1, 0, 0, 0, 0);
        @(negedge clk);
        chk("mid_rst_pv", bus.pcpi_valid, 1'b0);
        chk("mid_rst_insn", bus.pcpi_insn, 32'd0);
        chk("mid_rst_rs1", bus.pcpi_rs1, 32'd0);
        chk("mid_rst_rs2", bus.pcpi_rs2, 32'd0);
        chk("mid_rst_r1", bus.req1_ready, 1'b0);
        chk("mid_rst_rd1", bus.req1_rd, 32'd0);
        chk("mid_rst_wr1", bus.req1_wr, 1'b0);
        chk("mid_rst_err", err_timeout, 1'b0);
        resetn = 0;
        ri[0] = rand_insn(0); r1[0] = $urandom; r2[0] = $urandom;
        ri[1] = rand_insn(0);
        set_req(0, 1, ri[0], r1[0], r2[0]);
        set_req(1, 1, ri[1], 32'd1, 32'd1);
        @(negedge clk);
        chk("post_rst_grant", bus.pcpi_insn, ri[0]);
        bus.pcpi_ready = 1; bus.pcpi_wr = 1; bus.pcpi_rd = r1[0] * r2[0];
        @(negedge clk);
        bus.pcpi_ready = 0; bus.pcpi_wr = 0; bus.pcpi_rd = 0;
        chk("post_rst_r0", bus.req0_ready, 1'b1);
        chk("post_rst_rd0", bus.req0_rd, r1[0] * r2[0]);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
